pll_lock_supervisor: RTL and testbench
======================================

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL have parameter NUM_PLL, default 2: number of supervised PLLs, range 1..8.
REQ-002 SHALL have parameter RESET_PULSE_CYCLES, default 16: PLL reset pulse length in clk cycles, minimum 1.
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 27000: cycles allowed for all PLLs to reach lock after the pulse.
REQ-004 SHALL have parameter LOCK_STABLE_CYCLES, default 256: cycles all locks must stay high before release.
REQ-005 SHALL have parameter MAX_RETRIES, default 3: PLL reset pulses allowed after the initial pulse before fault, range 0..15.
REQ-006 SHALL have port clk, input, 1 bit: free-running reference clock, not PLL-derived.
REQ-007 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-008 SHALL have port pll_lock, input, NUM_PLL bits: raw, asynchronous PLL lock flags.
REQ-009 SHALL have port pll_reset, output, NUM_PLL bits: active-high reset to every PLL, all bits driven identically.
REQ-010 SHALL have port sys_reset_n, output, 1 bit: active-low downstream reset, released only in RUN.
REQ-011 SHALL have port locked_all, output, 1 bit: high only in RUN.
REQ-012 SHALL have port fault, output, 1 bit: sticky retry-exhausted flag.
REQ-013 SHALL have port retry_cnt, output, 4 bits: number of PLL reset pulses issued since the last entry to the initial pulse.

Function
REQ-014 SHALL pass each pll_lock bit through a 2-flop synchronizer; all decisions use the synchronized AND of all bits (lock_ok), giving 2 cycles of input latency.
REQ-015 SHALL implement states PULSE, WAIT_LOCK, STABLE, RUN and FAULT, using one shared down/up counter sized for the largest cycle parameter.
REQ-016 In PULSE, pll_reset SHALL be all-ones for exactly RESET_PULSE_CYCLES cycles, then the FSM enters WAIT_LOCK with the counter cleared.
REQ-017 In WAIT_LOCK, if lock_ok is high, the FSM SHALL enter STABLE with the counter cleared.
REQ-018 In WAIT_LOCK, if LOCK_TIMEOUT_CYCLES elapse without lock_ok: with retry_cnt<MAX_RETRIES, the FSM SHALL increment retry_cnt and enter PULSE; otherwise it SHALL enter FAULT.
REQ-019 In STABLE, if lock_ok stays high for LOCK_STABLE_CYCLES consecutive cycles, the FSM SHALL enter RUN.
REQ-020 In STABLE, any lock_ok low SHALL return the FSM to WAIT_LOCK with the timeout counter restarted; this does not count as a retry.
REQ-021 In RUN, sys_reset_n and locked_all SHALL be high, registered, and rise on the first cycle in RUN.
REQ-022 In RUN, lock_ok low SHALL drive sys_reset_n low and locked_all low on the next clock edge, clear retry_cnt to 0, and enter PULSE.
REQ-023 In FAULT, pll_reset SHALL be all-zeros, sys_reset_n low, locked_all low and fault high; the FSM SHALL remain in FAULT until reset_n is asserted, regardless of pll_lock.
REQ-024 sys_reset_n SHALL be low in every state except RUN; pll_reset SHALL be high only in PULSE.
REQ-025 With MAX_RETRIES=0, the first timeout SHALL go directly to FAULT.
REQ-026 All outputs SHALL be registered; no output SHALL depend combinationally on pll_lock.

Reset
REQ-027 On any clk edge with reset_n low: FSM=PULSE, counter=0, retry_cnt=0, synchronizers=0, pll_reset=all-ones, sys_reset_n=0, locked_all=0, fault=0.
REQ-028 Assertion of reset_n mid-operation, including in RUN or FAULT, SHALL take effect on the next edge; the pulse count restarts on the first edge with reset_n high.

Structure
REQ-029 State encoding and the counter-width function SHALL be defined in shared package clk_pkg.
REQ-030 The synchronizer SHALL be a separate sub-module, sync_2ff, instantiated once with width NUM_PLL.

Verification (NUM_PLL=2, RESET_PULSE=8, TIMEOUT=100, STABLE=16, MAX_RETRIES=2)
REQ-031 Bench SHALL cover: release reset_n, raise both locks 20 cycles later -> pll_reset high exactly 8 cycles, then sys_reset_n rises at lock+2+16 cycles (±1 cycle for the state-entry edge), retry_cnt=0.
REQ-032 Bench SHALL cover: hold lock[1]=0 throughout -> three 8-cycle pulses spaced 100 cycles apart, retry_cnt reaches 2, then fault=1, pll_reset=0, sys_reset_n=0, remaining until reset_n is asserted.
REQ-033 Bench SHALL cover: in RUN, drop lock[0] for 1 cycle -> sys_reset_n low 3 cycles later, a new 8-cycle pulse is issued, retry_cnt=0, and RUN is re-reached after relock.
REQ-034 Bench SHALL cover: in STABLE, glitch lock[1] low at stable-count 10 -> no pulse, retry_cnt unchanged, and a full 16 cycles are required again.
REQ-035 Bench SHALL cover: assert reset_n for 1 cycle while in FAULT -> fault=0 and pll_reset=all-ones on the next edge, and the sequence restarts.

Source files
------------

// File: rtl/clk_pkg.sv
// Shared state encoding and counter sizing helpers for the PLL lock supervisor.
package clk_pkg;

    typedef enum logic [2:0] {
        StPulse,
        StWaitLock,
        StStable,
        StRun,
        StFault
    } sup_state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Counter only ever holds 0..max_val-1.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val <= 1) ? 1 : $clog2(max_val);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus of independent asynchronous flags.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_d, meta_q;
    logic [WIDTH-1:0] sync_d, sync_q;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset pulses, waits for stable lock on all PLLs, then releases
// the downstream reset; retries on lock timeout and latches a fault when exhausted.
module pll_lock_supervisor
    import clk_pkg::*;
#(
    parameter int unsigned NUM_PLL             = 2,
    parameter int unsigned RESET_PULSE_CYCLES  = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 27000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 256,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_PLL-1:0] pll_lock,
    output logic [NUM_PLL-1:0] pll_reset,
    output logic               sys_reset_n,
    output logic               locked_all,
    output logic               fault,
    output logic [3:0]         retry_cnt
);

    localparam int unsigned CntMax =
        max3(RESET_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
    localparam int unsigned CntW = cnt_width(CntMax);

    typedef logic [CntW-1:0] cnt_t;

    localparam cnt_t       PulseLast   = cnt_t'(RESET_PULSE_CYCLES - 1);
    localparam cnt_t       TimeoutLast = cnt_t'(LOCK_TIMEOUT_CYCLES - 1);
    localparam cnt_t       StableLast  = cnt_t'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0] RetryLimit  = 4'(MAX_RETRIES);

    logic [NUM_PLL-1:0] lock_sync;
    logic               lock_ok;

    sup_state_e state_d, state_q;
    cnt_t       cnt_d, cnt_q;
    logic [3:0] retry_d, retry_q;
    logic       pll_reset_d, pll_reset_q;
    logic       sys_reset_n_d, sys_reset_n_q;
    logic       locked_all_d, locked_all_q;
    logic       fault_d, fault_q;

    sync_2ff #(
        .WIDTH (NUM_PLL)
    ) u_lock_sync (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .d_i      (pll_lock),
        .q_o      (lock_sync)
    );

    assign lock_ok = &lock_sync;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;

        unique case (state_q)
            StPulse: begin
                if (cnt_q == PulseLast) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            StWaitLock: begin
                if (lock_ok) begin
                    state_d = StStable;
                    cnt_d   = '0;
                end else if (cnt_q == TimeoutLast) begin
                    cnt_d = '0;
                    // retry_q never exceeds the limit, so equality marks exhaustion
                    if (retry_q != RetryLimit) begin
                        retry_d = retry_q + 4'd1;
                        state_d = StPulse;
                    end else begin
                        state_d = StFault;
                    end
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            StStable: begin
                if (!lock_ok) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else if (cnt_q == StableLast) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            StRun: begin
                if (!lock_ok) begin
                    state_d = StPulse;
                    cnt_d   = '0;
                    retry_d = 4'd0;
                end
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                state_d = StPulse;
                cnt_d   = '0;
            end
        endcase

        // Outputs decoded from the next state so they change on the state-entry edge.
        pll_reset_d   = (state_d == StPulse);
        sys_reset_n_d = (state_d == StRun);
        locked_all_d  = (state_d == StRun);
        fault_d       = (state_d == StFault);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= StPulse;
            cnt_q         <= '0;
            retry_q       <= 4'd0;
            pll_reset_q   <= 1'b1;
            sys_reset_n_q <= 1'b0;
            locked_all_q  <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            pll_reset_q   <= pll_reset_d;
            sys_reset_n_q <= sys_reset_n_d;
            locked_all_q  <= locked_all_d;
            fault_q       <= fault_d;
        end
    end

    assign pll_reset   = {NUM_PLL{pll_reset_q}};
    assign sys_reset_n = sys_reset_n_q;
    assign locked_all  = locked_all_q;
    assign fault       = fault_q;
    assign retry_cnt   = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with short pulse/timeout/stable settings.
module tb_pll_lock_supervisor;

    logic       clk;
    logic       reset_n;
    logic [1:0] pll_lock;
    logic [1:0] pll_reset;
    logic       sys_reset_n;
    logic       locked_all;
    logic       fault;
    logic [3:0] retry_cnt;

    int total = 0;
    int bad   = 0;

    pll_lock_supervisor #(
        .NUM_PLL             (2),
        .RESET_PULSE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (100),
        .LOCK_STABLE_CYCLES  (16),
        .MAX_RETRIES         (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pll_lock    (pll_lock),
        .pll_reset   (pll_reset),
        .sys_reset_n (sys_reset_n),
        .locked_all  (locked_all),
        .fault       (fault),
        .retry_cnt   (retry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return pll_reset[0];
            1:       return sys_reset_n;
            default: return fault;
        endcase
    endfunction

    // Ticks until the selected output reaches val; n = edges taken (budget on expiry).
    task automatic wait_sig(input int sel, input logic val, input int budget, output int n);
        n = 0;
        while (sig(sel) !== val && n < budget) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        logic saw_pulse;

        // Reset state
        reset_n  = 1'b0;
        pll_lock = 2'b00;
        repeat (3) tick();
        chk("rst_pll_reset", pll_reset, 2'b11);
        chk("rst_sys_reset_n", sys_reset_n, 0);
        chk("rst_locked_all", locked_all, 0);
        chk("rst_fault", fault, 0);
        chk("rst_retry", retry_cnt, 0);

        // Normal bring-up: locks rise 20 cycles after release
        reset_n = 1'b1;
        wait_sig(0, 1'b0, 50, n);
        chk("boot_pulse_len", n, 8);
        repeat (12) tick();
        pll_lock = 2'b11;
        wait_sig(1, 1'b1, 100, n);
        chk("boot_lock_to_run", n, 19);
        chk("boot_locked_all", locked_all, 1);
        chk("boot_retry", retry_cnt, 0);
        chk("boot_pll_reset", pll_reset, 2'b00);
        chk("boot_fault", fault, 0);

        // Single-cycle lock drop in RUN
        pll_lock = 2'b10;
        tick();
        pll_lock = 2'b11;
        wait_sig(1, 1'b0, 10, n);
        chk("drop_sys_delay", n, 2);
        chk("drop_locked_all", locked_all, 0);
        chk("drop_pll_reset", pll_reset, 2'b11);
        chk("drop_retry", retry_cnt, 0);
        wait_sig(0, 1'b0, 50, n);
        chk("drop_pulse_len", n, 8);
        wait_sig(1, 1'b1, 100, n);
        chk("drop_relock_run", n, 17);
        chk("drop_relock_retry", retry_cnt, 0);

        // Glitch during STABLE at stable-count 10
        pll_lock = 2'b00;
        wait_sig(1, 1'b0, 10, n);
        chk("glitch_enter_pulse", n, 3);
        wait_sig(0, 1'b0, 50, n);
        chk("glitch_pulse_len", n, 8);
        pll_lock = 2'b11;
        repeat (11) tick();
        pll_lock = 2'b01;
        tick();
        pll_lock = 2'b11;
        n = 0;
        saw_pulse = 1'b0;
        while (sys_reset_n !== 1'b1 && n < 60) begin
            tick();
            n++;
            if (pll_reset !== 2'b00) saw_pulse = 1'b1;
        end
        chk("glitch_run_delay", n, 19);
        chk("glitch_no_pulse", saw_pulse, 0);
        chk("glitch_retry", retry_cnt, 0);

        // Lock[1] never asserts: retries exhausted into FAULT
        reset_n  = 1'b0;
        pll_lock = 2'b01;
        repeat (2) tick();
        reset_n = 1'b1;
        wait_sig(0, 1'b0, 50, n);
        chk("to_pulse0_len", n, 8);
        chk("to_retry0", retry_cnt, 0);
        wait_sig(0, 1'b1, 200, n);
        chk("to_gap1", n, 100);
        chk("to_retry1", retry_cnt, 1);
        wait_sig(0, 1'b0, 50, n);
        chk("to_pulse1_len", n, 8);
        wait_sig(0, 1'b1, 200, n);
        chk("to_gap2", n, 100);
        chk("to_retry2", retry_cnt, 2);
        wait_sig(0, 1'b0, 50, n);
        chk("to_pulse2_len", n, 8);
        wait_sig(2, 1'b1, 200, n);
        chk("to_fault_delay", n, 100);
        chk("to_fault_pll_reset", pll_reset, 2'b00);
        chk("to_fault_sys", sys_reset_n, 0);
        chk("to_fault_locked", locked_all, 0);
        chk("to_fault_retry", retry_cnt, 2);
        pll_lock = 2'b11;
        repeat (50) tick();
        chk("fault_sticky", fault, 1);
        chk("fault_sticky_sys", sys_reset_n, 0);
        chk("fault_sticky_pll_reset", pll_reset, 2'b00);

        // One-cycle reset out of FAULT restarts the sequence
        reset_n = 1'b0;
        tick();
        chk("frst_fault", fault, 0);
        chk("frst_pll_reset", pll_reset, 2'b11);
        chk("frst_retry", retry_cnt, 0);
        reset_n = 1'b1;
        wait_sig(0, 1'b0, 50, n);
        chk("frst_pulse_len", n, 8);
        wait_sig(1, 1'b1, 100, n);
        chk("frst_run_delay", n, 17);
        chk("frst_locked_all", locked_all, 1);
        chk("frst_fault_low", fault, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
